// File: rtl/adc_scan_pkg.sv
// Shared types, default timing constants and the channel-search helper
// for the ADC scan sequencer.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CONVERT,
        S_CAPTURE,
        S_NEXT
    } scan_state_t;

    localparam int DEF_SETTLE_CYCLES  = 1000;
    localparam int DEF_TIMEOUT_CYCLES = 2000000;
    localparam int MAX_CH             = 16;

    // Lowest set bit of mask at index >= from; returns 16 when none exists.
    function automatic logic [4:0] next_set_bit(input logic [15:0] mask, input logic [4:0] from);
        logic [4:0] r;
        r = 5'd16;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= from)) r = 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module adc_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        cnt <= '0;
        else if (load)       cnt <= load_val;
        else if (cnt != '0)  cnt <= cnt - W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/adc_scan_sequencer.sv
// Multi-channel ADC scan sequencer: settle, convert, capture, advance.
// Define ADC_SCAN_DISCARD_EN to drop the first ready pulse of each conversion.
module adc_scan_sequencer
    import adc_scan_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int NUM_CH         = 4,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int SW            = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              algo_sar_cfg,
    output logic              adc_enable,
    output logic              adc_algo_sar,
    input  logic              adc_ready_pulse,
    input  logic [WIDTH-1:0]  adc_raw8,
    output logic [SW-1:0]     mux_sel,
    output logic              result_valid,
    output logic [SW-1:0]     result_ch,
    output logic [WIDTH-1:0]  result_data,
    input  logic [SW-1:0]     rd_ch,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              scan_done,
    output logic              timeout_err
);

    localparam int DEPTH = 1 << SW;
    localparam int TMAX  = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    scan_state_t state, state_nxt;

    logic [NUM_CH-1:0] lat_mask;
    logic              lat_algo;
    logic              lat_cont;
    logic [WIDTH-1:0]  bank [DEPTH];

    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;

    logic do_start, do_advance, do_wrap, do_capture, do_timeout;
    logic [4:0] low_in, low_lat, nxt_hi;
`ifdef ADC_SCAN_DISCARD_EN
    logic discarded;
    logic do_discard;
`endif

    assign low_in  = next_set_bit(16'(ch_mask), 5'd0);
    assign low_lat = next_set_bit(16'(lat_mask), 5'd0);
    assign nxt_hi  = next_set_bit(16'(lat_mask), 5'(mux_sel) + 5'd1);

    // Upper search bits only flag "not found"; the slices below drop them.
    logic unused_search;
    assign unused_search = ^{low_in[4:SW], low_lat[4:SW]};

    adc_cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        timer_val  = '0;
        do_start   = 1'b0;
        do_advance = 1'b0;
        do_wrap    = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        scan_done  = 1'b0;
`ifdef ADC_SCAN_DISCARD_EN
        do_discard = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start && (ch_mask != '0)) begin
                    do_start   = 1'b1;
                    state_nxt  = S_SETTLE;
                    timer_load = 1'b1;
                    timer_val  = TW'(SETTLE_CYCLES - 1);
                end
            end
            S_SETTLE: begin
                if (abort) state_nxt = S_IDLE;
                else if (timer_done) begin
                    state_nxt  = S_CONVERT;
                    timer_load = 1'b1;
                    timer_val  = TW'(TIMEOUT_CYCLES - 1);
                end
            end
            S_CONVERT: begin
                if (abort) state_nxt = S_IDLE;
                else if (adc_ready_pulse) begin
`ifdef ADC_SCAN_DISCARD_EN
                    if (!discarded) begin
                        do_discard = 1'b1;
                        timer_load = 1'b1;
                        timer_val  = TW'(TIMEOUT_CYCLES - 1);
                    end else begin
                        state_nxt = S_CAPTURE;
                    end
`else
                    state_nxt = S_CAPTURE;
`endif
                end else if (timer_done) begin
                    do_timeout = 1'b1;
                    state_nxt  = S_NEXT;
                end
            end
            S_CAPTURE: begin
                if (abort) state_nxt = S_IDLE;
                else begin
                    do_capture = 1'b1;
                    state_nxt  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (abort) state_nxt = S_IDLE;
                else if (!nxt_hi[4] && (32'(nxt_hi) < NUM_CH)) begin
                    do_advance = 1'b1;
                    state_nxt  = S_SETTLE;
                    timer_load = 1'b1;
                    timer_val  = TW'(SETTLE_CYCLES - 1);
                end else begin
                    scan_done = 1'b1;
                    if (lat_cont) begin
                        do_wrap    = 1'b1;
                        state_nxt  = S_SETTLE;
                        timer_load = 1'b1;
                        timer_val  = TW'(SETTLE_CYCLES - 1);
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_mask     <= '0;
            lat_algo     <= 1'b0;
            lat_cont     <= 1'b0;
            mux_sel      <= '0;
            timeout_err  <= 1'b0;
            result_valid <= 1'b0;
            result_ch    <= '0;
            result_data  <= '0;
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else begin
            result_valid <= do_capture;
            if (do_start) begin
                lat_mask    <= ch_mask;
                lat_algo    <= algo_sar_cfg;
                lat_cont    <= continuous;
                timeout_err <= 1'b0;
                mux_sel     <= low_in[SW-1:0];
            end
            if (do_advance) mux_sel <= nxt_hi[SW-1:0];
            if (do_wrap) begin
                mux_sel  <= low_lat[SW-1:0];
                lat_cont <= continuous;
            end
            if (do_timeout) timeout_err <= 1'b1;
            if (do_capture) begin
                result_ch     <= mux_sel;
                result_data   <= adc_raw8;
                bank[mux_sel] <= adc_raw8;
            end
        end
    end

`ifdef ADC_SCAN_DISCARD_EN
    // Re-armed on every CONVERT entry so each conversion drops its own first pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                      discarded <= 1'b0;
        else if (state_nxt == S_CONVERT && state != S_CONVERT) discarded <= 1'b0;
        else if (do_discard)                               discarded <= 1'b1;
    end
`endif

    assign busy         = (state != S_IDLE);
    assign adc_enable   = (state == S_CONVERT);
    assign adc_algo_sar = (state == S_CONVERT) && lat_algo;
    assign rd_data      = bank[rd_ch];

endmodule
